dma_arbiter: RTL and testbench

- Shares the single SDRAM DMA command port among up to NREQ requesters: command fetch, weight fetch, data fetch and result write-back.
- Grants one requester at a time with round-robin priority and holds the grant for a whole burst.
- Issues one memory command per grant, then counts the data beats and releases the grant on the last one.
- Sits between the command sequencer / compute engines and the memory-controller port.

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_arbiter_rr_picker.sv | 31 +++
 rtl/dma_arbiter.sv | 103 ++++++++++
 tb/tb_dma_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the SDRAM DMA command-port arbiter: memory command
// encodings, FSM state type and default address / burst-length widths.
package dma_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int BL_W_DEF   = 6;

    localparam logic [2:0] MEM_INSTR_WR = 3'b000;
    localparam logic [2:0] MEM_INSTR_RD = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } state_t;

endpackage

// File: rtl/dma_arbiter_rr_picker.sv
// Combinational round-robin picker: scans req starting just after the last
// winner (with wrap) and returns the first set bit as one-hot plus index.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    always_comb begin
        int cand;
        cand       = 0;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        // k = N wraps back to last itself, so a lone requester can win again.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!valid && req[cand]) begin
                winner[cand] = 1'b1;
                winner_idx   = IDX_W'(cand);
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter for the single SDRAM DMA command port: grants one
// requester per burst, issues its command, then counts data beats to release.
module dma_arbiter
    import dma_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BL_W   = BL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*BL_W-1:0]   req_bl,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic [BL_W-1:0]        beat_cnt,
    output logic                   mem_cmd_en,
    output logic [2:0]             mem_cmd_instr,
    output logic [ADDR_W-1:0]      mem_cmd_addr,
    output logic [BL_W-1:0]        mem_cmd_bl,
    input  logic                   mem_cmd_full,
    input  logic                   beat_done,
    output logic                   err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state, state_next;
    logic [IDX_W-1:0] last, owner;
    logic [NREQ-1:0]  pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             last_beat;

    rr_picker #(.N(NREQ), .IDX_W(IDX_W)) u_picker (
        .req        (req),
        .last       (last),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign mem_cmd_en = (state == ISSUE) && !mem_cmd_full;
    assign busy       = (state != IDLE);
    assign last_beat  = beat_done && (beat_cnt == mem_cmd_bl);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   if (mem_cmd_en) state_next = XFER;
            XFER:    if (last_beat)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, latched command and beat counter; the command fields are
    // captured once in IDLE so the owner may change its inputs afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt           <= '0;
            last          <= IDX_W'(NREQ - 1);
            owner         <= '0;
            beat_cnt      <= '0;
            mem_cmd_addr  <= '0;
            mem_cmd_bl    <= '0;
            mem_cmd_instr <= '0;
            err           <= 1'b0;
        end else begin
            if (beat_done && (state != XFER)) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt           <= pick_oh;
                        owner         <= pick_idx;
                        mem_cmd_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        mem_cmd_bl    <= req_bl[pick_idx*BL_W +: BL_W];
                        mem_cmd_instr <= req_wr[pick_idx] ? MEM_INSTR_WR : MEM_INSTR_RD;
                        beat_cnt      <= '0;
                    end
                end
                XFER: begin
                    if (last_beat) begin
                        gnt      <= '0;
                        last     <= owner;
                        beat_cnt <= '0;
                    end else if (beat_done) begin
                        beat_cnt <= beat_cnt + BL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed self-checking bench for dma_arbiter: reset, single read, fairness,
// backpressure, withdrawal, protocol error and reset in the middle of a burst.
module tb_dma_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_wr;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*BL_W-1:0]   req_bl;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic [BL_W-1:0]        beat_cnt;
    logic                   mem_cmd_en;
    logic [2:0]             mem_cmd_instr;
    logic [ADDR_W-1:0]      mem_cmd_addr;
    logic [BL_W-1:0]        mem_cmd_bl;
    logic                   mem_cmd_full;
    logic                   beat_done;
    logic                   err;

    int passed = 0;
    int total  = 0;
    int cmd_count = 0;

    dma_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .BL_W(BL_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_bl        (req_bl),
        .gnt           (gnt),
        .busy          (busy),
        .beat_cnt      (beat_cnt),
        .mem_cmd_en    (mem_cmd_en),
        .mem_cmd_instr (mem_cmd_instr),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_bl    (mem_cmd_bl),
        .mem_cmd_full  (mem_cmd_full),
        .beat_done     (beat_done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_cmd_en) cmd_count <= cmd_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [BL_W-1:0] bl);
        req_wr[i]                  = wr;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_bl[i*BL_W +: BL_W]       = bl;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; beat_done = 1'b0; mem_cmd_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (beat_cnt !== 6'd0) $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); else passed++;
        total++; if (mem_cmd_addr !== 30'd0) $display("FAIL reset_addr: got %h want 0", mem_cmd_addr); else passed++;
        total++; if (mem_cmd_bl !== 6'd0) $display("FAIL reset_bl: got %0d want 0", mem_cmd_bl); else passed++;
        total++; if (mem_cmd_instr !== 3'b000) $display("FAIL reset_instr: got %b want 000", mem_cmd_instr); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
        total++; if (mem_cmd_en !== 1'b0) $display("FAIL reset_en: got %b want 0", mem_cmd_en); else passed++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL idle_no_req_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_single_read();
        set_slot(0, 1'b0, 30'h0000100, 6'd3);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b0001) $display("FAIL read_gnt: got %b want 0001", gnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL read_busy: got %b want 1", busy); else passed++;
        total++; if (mem_cmd_en !== 1'b1) $display("FAIL read_en: got %b want 1", mem_cmd_en); else passed++;
        total++; if (mem_cmd_instr !== 3'b001) $display("FAIL read_instr: got %b want 001", mem_cmd_instr); else passed++;
        total++; if (mem_cmd_addr !== 30'h100) $display("FAIL read_addr: got %h want 100", mem_cmd_addr); else passed++;
        total++; if (mem_cmd_bl !== 6'd3) $display("FAIL read_bl: got %0d want 3", mem_cmd_bl); else passed++;
        tick();
        total++; if (mem_cmd_en !== 1'b0) $display("FAIL read_en_xfer: got %b want 0", mem_cmd_en); else passed++;
        beat_done = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            tick();
            total++; if (beat_cnt !== 6'(b)) $display("FAIL read_beat_cnt: got %0d want %0d", beat_cnt, b); else passed++;
            total++; if (gnt !== 4'b0001) $display("FAIL read_gnt_hold: got %b want 0001", gnt); else passed++;
        end
        tick();
        beat_done = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL read_release_gnt: got %b want 0000", gnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL read_release_busy: got %b want 0", busy); else passed++;
        total++; if (beat_cnt !== 6'd0) $display("FAIL read_release_cnt: got %0d want 0", beat_cnt); else passed++;
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_slot(i, 1'b0, ADDR_W'(i * 16'h1000), 6'd0);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp = 4'b0001 << (k % 4);
            tick();
            total++; if (gnt !== exp) $display("FAIL fair_gnt_%0d: got %b want %b", k, gnt, exp); else passed++;
            total++; if (mem_cmd_en !== 1'b1) $display("FAIL fair_en_%0d: got %b want 1", k, mem_cmd_en); else passed++;
            tick();
            beat_done = 1'b1;
            tick();
            beat_done = 1'b0;
            total++; if (gnt !== 4'b0000) $display("FAIL fair_gap_gnt_%0d: got %b want 0000", k, gnt); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL fair_gap_busy_%0d: got %b want 0", k, busy); else passed++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        int base;
        set_slot(2, 1'b1, 30'h0002000, 6'd1);
        mem_cmd_full = 1'b1;
        base = cmd_count;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b0100) $display("FAIL bp_gnt: got %b want 0100", gnt); else passed++;
        for (int c = 0; c < 3; c++) begin
            total++; if (mem_cmd_en !== 1'b0) $display("FAIL bp_en_held_%0d: got %b want 0", c, mem_cmd_en); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL bp_busy_%0d: got %b want 1", c, busy); else passed++;
            tick();
        end
        mem_cmd_full = 1'b0;
        #1;
        total++; if (mem_cmd_en !== 1'b1) $display("FAIL bp_en_release: got %b want 1", mem_cmd_en); else passed++;
        total++; if (mem_cmd_instr !== 3'b000) $display("FAIL bp_instr: got %b want 000", mem_cmd_instr); else passed++;
        total++; if (mem_cmd_addr !== 30'h2000) $display("FAIL bp_addr: got %h want 2000", mem_cmd_addr); else passed++;
        tick();
        total++; if (mem_cmd_en !== 1'b0) $display("FAIL bp_en_after: got %b want 0", mem_cmd_en); else passed++;
        beat_done = 1'b1;
        tick(); tick();
        beat_done = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL bp_release_gnt: got %b want 0000", gnt); else passed++;
        total++; if (cmd_count - base !== 1) $display("FAIL bp_cmd_count: got %0d want 1", cmd_count - base); else passed++;
    endtask

    task automatic test_withdrawal();
        set_slot(3, 1'b0, 30'h0003000, 6'd2);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b1000) $display("FAIL wd_gnt_owner: got %b want 1000", gnt); else passed++;
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b1000) $display("FAIL wd_gnt_hold: got %b want 1000", gnt); else passed++;
        beat_done = 1'b1;
        tick(); tick(); tick();
        beat_done = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL wd_release: got %b want 0000", gnt); else passed++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (gnt !== 4'b0000) $display("FAIL wd_no_grant_%0d: got %b want 0000", c, gnt); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL wd_idle_%0d: got %b want 0", c, busy); else passed++;
        end
    endtask

    task automatic test_error();
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        total++; if (err !== 1'b1) $display("FAIL err_idle_set: got %b want 1", err); else passed++;
        total++; if (beat_cnt !== 6'd0) $display("FAIL err_idle_cnt: got %0d want 0", beat_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL err_idle_busy: got %b want 0", busy); else passed++;
        set_slot(0, 1'b0, 30'h0000040, 6'd0);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b0001) $display("FAIL err_burst_gnt: got %b want 0001", gnt); else passed++;
        tick();
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL err_burst_release: got %b want 0000", gnt); else passed++;
        total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (err !== 1'b0) $display("FAIL err_rst_clear: got %b want 0", err); else passed++;
        mem_cmd_full = 1'b1;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        total++; if (err !== 1'b1) $display("FAIL err_issue_set: got %b want 1", err); else passed++;
        total++; if (beat_cnt !== 6'd0) $display("FAIL err_issue_cnt: got %0d want 0", beat_cnt); else passed++;
        mem_cmd_full = 1'b0;
        tick();
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL err_issue_release: got %b want 0000", gnt); else passed++;
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset_mid_xfer();
        int base;
        set_slot(0, 1'b1, 30'h0000500, 6'd7);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        beat_done = 1'b1;
        tick(); tick();
        beat_done = 1'b0;
        total++; if (beat_cnt !== 6'd2) $display("FAIL mid_cnt: got %0d want 2", beat_cnt); else passed++;
        base = cmd_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want 0000", gnt); else passed++;
        total++; if (beat_cnt !== 6'd0) $display("FAIL mid_rst_cnt: got %0d want 0", beat_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
        tick();
        total++; if (cmd_count - base !== 0) $display("FAIL mid_no_reissue: got %0d want 0", cmd_count - base); else passed++;
        set_slot(0, 1'b0, 30'h0000700, 6'd0);
        set_slot(3, 1'b0, 30'h0000600, 6'd0);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b1000) $display("FAIL mid_gnt3: got %b want 1000", gnt); else passed++;
        total++; if (mem_cmd_addr !== 30'h600) $display("FAIL mid_addr3: got %h want 600", mem_cmd_addr); else passed++;
        tick();
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        req = 4'b1001;
        tick();
        req = 4'b0000;
        total++; if (gnt !== 4'b0001) $display("FAIL mid_gnt0: got %b want 0001", gnt); else passed++;
        tick();
        beat_done = 1'b1;
        tick();
        beat_done = 1'b0;
        total++; if (gnt !== 4'b0000) $display("FAIL mid_final_release: got %b want 0000", gnt); else passed++;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_bl = '0;
        mem_cmd_full = 1'b0; beat_done = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_withdrawal();
        test_error();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
